nx_wrr_pkt_arb: RTL and testbench
=================================

# nx_wrr_pkt_arb

Weighted round-robin packet arbiter and mux. It shares one downstream streaming port among N upstream requesters at packet granularity, so a packet is never interleaved. Each requester may send up to its configured weight in consecutive packets before the turn passes. It sits in front of shared engines, such as a compression core or DMA write port, that accept one packet stream.

## Interface
- N, 4, number of requesters (2..16)
- DW, 64, data beat width
- WT_W, 4, per-requester weight width
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  allows new packet grants; does not cut a packet in flight
- weight  in  N*WT_W  packets per turn per requester, quasi-static; 0 treated as 1
- in_valid  in  N  per-requester beat valid
- in_data  in  N*DW  per-requester beat data, slice i = requester i
- in_eop  in  N  last beat of packet
- in_ready  out  N  per-requester beat accept
- out_valid  out  1  registered output beat valid
- out_data  out  DW  registered output beat data
- out_eop  out  1  registered last beat
- out_src  out  $clog2(N)  requester index of out beat
- out_ready  in  1  downstream accept
- stall_err  out  1  sticky watchdog error (see Configuration)

## Operation
- FSM states: ARB and XFER. Reset state is ARB.
- ARB, enable=1, any in_valid:
  - If quota_r>0 and in_valid[owner_r], keep owner_r.
  - Otherwise pick the first valid requester scanning owner_r+1 .. N-1, 0 .. owner_r (wrap). Load quota_r = max(weight[new],1)-1.
  - Same-owner continuation decrements quota_r.
  - Go to XFER.
- ARB, enable=0 or no in_valid: stay in ARB; owner_r and quota_r hold.
- XFER:
  - in_ready[owner_r] = !out_valid | out_ready. All other in_ready are 0.
  - Beat transfers when in_valid & in_ready are both high. The beat is registered into out_* with out_src=owner_r.
  - On the eop beat transfer, return to ARB.
- enable deasserting in XFER has no effect until eop.
- Output stage is a single register:
  - out_valid clears when out_ready=1 and no new beat loads that cycle.
  - out_* hold while out_valid & !out_ready.
- in_valid dropping mid-packet is legal. The FSM stays in XFER, waiting.
- Reset values:
  - owner_r = N-1, so requester 0 wins first.
  - quota_r = 0, state = ARB.
  - out_valid = 0, out_data = 0, out_eop = 0, out_src = 0.
  - in_ready = 0, stall_err = 0.
- Reset mid-packet discards the partial packet. Upstream must also be reset.

## Timing
- Grant decision: one cycle in ARB. The first in_ready is high in the cycle after ARB sees in_valid.
- Input beat to out_valid: 1 cycle.
- Packet to packet: one ARB bubble cycle, including same-owner continuation.
- Sustained throughput within a packet: one beat per cycle when out_ready=1.
- weight is sampled only in ARB on an owner change.

## Configuration
- NX_WRR_PKT_ARB_WDOG_EN defined:
  - A 16-bit counter counts XFER cycles with no beat transfer. It clears on any transfer and on entry to ARB.
  - At 0xFFFF, stall_err sets and stays set until rst_n.
  - Arbitration is unaffected.
- Macro undefined: counter absent, stall_err tied 0.

## Structure
- Package nx_wrr_pkt_arb_pkg holds:
  - the state enum (ARB, XFER)
  - the WDOG_MAX constant (16'hFFFF)
- Sub-module nx_rr_pick is a combinational rotating-priority picker.
  - Inputs: req[N], ptr.
  - Outputs: idx, found.
  - It is instantiated once for the wrap scan.

## Test plan
- Reset, then in_valid=4'b1111, all weights 1, single-beat packets, out_ready=1 -> out_src sequence 0,1,2,3,0; first out_valid 2 cycles after in_valid.
- weight[1]=3, weight[0]=1, requesters 0 and 1 continuously valid -> out_src 0,1,1,1,0,1,1,1.
- Requester 2 sends a 4-beat packet while requester 0 is valid; out_ready held 0 for 3 cycles mid-packet -> beats contiguous and unduplicated, out_* stable while stalled, requester 0 granted only after the eop.
- enable dropped on beat 2 of a 5-beat packet -> packet completes; no new grant while enable=0; resumes from the next requester after owner_r.
- rst_n asserted mid-packet -> out_valid=0 and in_ready=0 immediately; after release, requester 0 is granted first.
- WDOG_EN build: owner holds in_valid=0 mid-packet for 65535 cycles -> stall_err=1 and sticky. Non-WDOG build -> stall_err stays 0.

Source files
------------

// File: rtl/nx_wrr_pkt_arb_pkg.sv
// Shared types and constants for the weighted round-robin packet arbiter.
package nx_wrr_pkt_arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam logic [15:0] WDOG_MAX = 16'hFFFF;

endpackage

// File: rtl/nx_rr_pick.sv
// Combinational rotating-priority picker: returns the first set request
// scanning i_ptr+1 .. N-1, 0 .. i_ptr. i_ptr itself has the lowest priority.
module nx_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_found
);

    localparam int SW = $clog2(N);

    int w_best;
    int w_d;

    // Rank every requester by its distance past the pointer; keep the closest.
    always_comb begin
        o_idx   = '0;
        o_found = |i_req;
        w_best  = N;
        w_d     = 0;
        for (int j = 0; j < N; j++) begin
            if (i_req[j]) begin
                w_d = (j + N - 1 - int'(i_ptr)) % N;
                if (w_d < w_best) begin
                    w_best = w_d;
                    o_idx  = SW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/nx_wrr_pkt_arb.sv
// Weighted round-robin packet arbiter and mux. Grants one requester per
// packet; a requester may keep the port for up to its weight in consecutive
// packets. Output beat stage is a single register.
// Optional build macro NX_WRR_PKT_ARB_WDOG_EN adds a stall watchdog that
// drives the sticky o_stall_err; without it o_stall_err is tied low.
import nx_wrr_pkt_arb_pkg::*;

module nx_wrr_pkt_arb #(
    parameter int N    = 4,
    parameter int DW   = 64,
    parameter int WT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_enable,
    input  logic [N*WT_W-1:0]    i_weight,
    input  logic [N-1:0]         i_in_valid,
    input  logic [N*DW-1:0]      i_in_data,
    input  logic [N-1:0]         i_in_eop,
    output logic [N-1:0]         o_in_ready,
    output logic                 o_out_valid,
    output logic [DW-1:0]        o_out_data,
    output logic                 o_out_eop,
    output logic [$clog2(N)-1:0] o_out_src,
    input  logic                 i_out_ready,
    output logic                 o_stall_err
);

    localparam int SW = $clog2(N);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [SW-1:0]   r_owner;
    logic [SW-1:0]   w_owner_nxt;
    logic [WT_W-1:0] r_quota;
    logic [WT_W-1:0] w_quota_nxt;

    logic [SW-1:0]   w_pick_idx;
    logic            w_pick_found;
    logic [WT_W-1:0] w_pick_wt;

    logic            w_own_valid;
    logic            w_own_eop;
    logic [DW-1:0]   w_own_data;
    logic            w_beat_rdy;
    logic            w_xfer;

    logic            r_out_valid;
    logic [DW-1:0]   r_out_data;
    logic            r_out_eop;
    logic [SW-1:0]   r_out_src;

    nx_rr_pick #(.N(N)) u_pick (
        .i_req   (i_in_valid),
        .i_ptr   (r_owner),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    assign w_pick_wt   = i_weight[int'(w_pick_idx)*WT_W +: WT_W];
    assign w_own_valid = i_in_valid[r_owner];
    assign w_own_eop   = i_in_eop[r_owner];
    assign w_own_data  = i_in_data[int'(r_owner)*DW +: DW];
    assign w_beat_rdy  = (r_state == XFER) && (!r_out_valid || i_out_ready);
    assign w_xfer      = w_beat_rdy && w_own_valid;

    // Next-state, grant selection and per-requester ready.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_quota_nxt = r_quota;
        o_in_ready  = '0;
        case (r_state)
            ARB: begin
                if (i_enable && w_pick_found) begin
                    if ((r_quota != '0) && w_own_valid) begin
                        w_quota_nxt = r_quota - WT_W'(1);
                    end else begin
                        w_owner_nxt = w_pick_idx;
                        // A weight of 0 behaves as 1: no extra packets.
                        w_quota_nxt = (w_pick_wt == '0) ? '0 : (w_pick_wt - WT_W'(1));
                    end
                    w_state_nxt = XFER;
                end
            end
            XFER: begin
                o_in_ready[r_owner] = w_beat_rdy;
                if (w_xfer && w_own_eop) begin
                    w_state_nxt = ARB;
                end
            end
            default: w_state_nxt = ARB;
        endcase
    end

    // FSM state, current owner and remaining packet quota.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB;
            r_owner <= SW'(N - 1);
            r_quota <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_quota <= w_quota_nxt;
        end
    end

    // Output beat register: load on transfer, drain when downstream accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_eop   <= 1'b0;
            r_out_src   <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_own_data;
            r_out_eop   <= w_own_eop;
            r_out_src   <= r_owner;
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_eop   = r_out_eop;
    assign o_out_src   = r_out_src;

`ifdef NX_WRR_PKT_ARB_WDOG_EN
    logic [15:0] r_wdog;
    logic        r_stall_err;

    // Count idle XFER cycles; a full count latches the sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog      <= '0;
            r_stall_err <= 1'b0;
        end else begin
            if ((r_state != XFER) || w_xfer) begin
                r_wdog <= '0;
            end else if (r_wdog != WDOG_MAX) begin
                r_wdog <= r_wdog + 16'd1;
            end
            if (r_wdog == WDOG_MAX) begin
                r_stall_err <= 1'b1;
            end
        end
    end

    assign o_stall_err = r_stall_err;
`else
    assign o_stall_err = 1'b0;
`endif

endmodule

// File: tb/tb_nx_wrr_pkt_arb.sv
// Testbench for nx_wrr_pkt_arb: per-requester packet sources, a packet-level
// weighted round-robin model producing the expected beat stream, and a
// per-cycle monitor comparing DUT output against it.
module tb_nx_wrr_pkt_arb;

    localparam int N    = 4;
    localparam int DW   = 64;
    localparam int WT_W = 4;
    localparam int SW   = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic [N*WT_W-1:0] weight = '0;
    logic [N-1:0]      in_valid = '0;
    logic [N*DW-1:0]   in_data = '0;
    logic [N-1:0]      in_eop = '0;
    logic [N-1:0]      in_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic              out_eop;
    logic [SW-1:0]     out_src;
    logic              out_ready = 1'b0;
    logic              stall_err;

    nx_wrr_pkt_arb #(.N(N), .DW(DW), .WT_W(WT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_enable    (enable),
        .i_weight    (weight),
        .i_in_valid  (in_valid),
        .i_in_data   (in_data),
        .i_in_eop    (in_eop),
        .o_in_ready  (in_ready),
        .o_out_valid (out_valid),
        .o_out_data  (out_data),
        .o_out_eop   (out_eop),
        .o_out_src   (out_src),
        .i_out_ready (out_ready),
        .o_stall_err (stall_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [DW-1:0] data; logic eop; } beat_t;
    typedef struct { logic [DW-1:0] data; logic eop; int src; } xbeat_t;

    beat_t  src_q [N][$];
    bit     hold [N];
    int     mdl_len [N][$];
    int     mdl_pid [N][$];
    int     mdl_wt [N];
    int     mdl_owner;
    int     mdl_quota;
    xbeat_t exp_q [$];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int pid_ctr = 0;
    int obs_src [$];
    int obs_cyc [$];
    int first_iv = -1;
    int first_ov = -1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] gen_data(int s, int p, int b);
        return {16'hC0DE, 8'(s), 8'(p), 16'(b), 16'(p * 37 + b * 5 + s)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_tmo(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: wait expired, %0d beats outstanding, expected 0", name, exp_q.size());
    endtask

    task automatic add_pkt(input int s, input int len);
        beat_t bt;
        int pid;
        pid = pid_ctr++;
        for (int b = 0; b < len; b++) begin
            bt.data = gen_data(s, pid, b);
            bt.eop  = (b == len - 1);
            src_q[s].push_back(bt);
        end
        mdl_len[s].push_back(len);
        mdl_pid[s].push_back(pid);
    endtask

    // Packet-level WRR: order every pending packet and expand it into beats.
    task automatic plan();
        bit     any;
        int     nxt;
        int     c;
        int     len;
        int     pid;
        xbeat_t xb;
        forever begin
            any = 0;
            for (int i = 0; i < N; i++) if (mdl_len[i].size() > 0) any = 1;
            if (!any) break;
            if (mdl_quota > 0 && mdl_len[mdl_owner].size() > 0) begin
                mdl_quota--;
            end else begin
                nxt = mdl_owner;
                for (int k = N; k >= 1; k--) begin
                    c = (mdl_owner + k) % N;
                    if (mdl_len[c].size() > 0) nxt = c;
                end
                mdl_owner = nxt;
                mdl_quota = ((mdl_wt[nxt] == 0) ? 1 : mdl_wt[nxt]) - 1;
            end
            len = mdl_len[mdl_owner].pop_front();
            pid = mdl_pid[mdl_owner].pop_front();
            for (int b = 0; b < len; b++) begin
                xb.data = gen_data(mdl_owner, pid, b);
                xb.eop  = (b == len - 1);
                xb.src  = mdl_owner;
                exp_q.push_back(xb);
            end
        end
    endtask

    task automatic set_wt(input int w0, input int w1, input int w2, input int w3);
        mdl_wt[0] = w0; mdl_wt[1] = w1; mdl_wt[2] = w2; mdl_wt[3] = w3;
        for (int i = 0; i < N; i++) weight[i*WT_W +: WT_W] = WT_W'(mdl_wt[i]);
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            mdl_len[i].delete();
            mdl_pid[i].delete();
            hold[i] = 0;
        end
        exp_q.delete();
        obs_src.delete();
        obs_cyc.delete();
        mdl_owner = N - 1;
        mdl_quota = 0;
        first_iv  = -1;
        first_ov  = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        enable = 1'b0;
        clear_all();
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_eop", out_eop, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_src", out_src, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_stall_err", stall_err, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain(input string name, input int budget);
        int t;
        bit busy;
        t = 0;
        forever begin
            busy = (exp_q.size() > 0);
            for (int i = 0; i < N; i++) if (src_q[i].size() > 0) busy = 1;
            if (!busy || t >= budget) break;
            @(negedge clk);
            t++;
        end
        if (t >= budget) fail_tmo(name);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_obs(input string name, input int nbeats, input int budget);
        int t;
        t = 0;
        while (obs_cyc.size() < nbeats && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (t >= budget) fail_tmo(name);
    endtask

    task automatic chk_seq(input string name, input int seq[8], input int n);
        check({name, "_count"}, obs_src.size(), n);
        for (int k = 0; k < n; k++) begin
            if (k < obs_src.size()) check($sformatf("%s[%0d]", name, k), obs_src[k], seq[k]);
        end
    endtask

    // Upstream sources: present queue heads, pop on handshake.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (!hold[i] && src_q[i].size() > 0) begin
                    in_valid[i]            = 1'b1;
                    in_data[i*DW +: DW]    = src_q[i][0].data;
                    in_eop[i]              = src_q[i][0].eop;
                end else begin
                    in_valid[i]            = 1'b0;
                    in_data[i*DW +: DW]    = '0;
                    in_eop[i]              = 1'b0;
                end
            end
            #3;
            for (int i = 0; i < N; i++) begin
                if (rst_n && in_valid[i] && in_ready[i]) void'(src_q[i].pop_front());
            end
        end
    end

    // Per-cycle compare of DUT output against the expected beat stream.
    initial begin
        bit            stl_prev;
        logic [DW-1:0] stl_data;
        logic          stl_eop;
        logic [SW-1:0] stl_src;
        xbeat_t        e;
        stl_prev = 0;
        stl_data = '0;
        stl_eop  = 0;
        stl_src  = '0;
        forever begin
            @(negedge clk);
            #4;
            if (rst_n) begin
                check("in_ready_onehot0", $onehot0(in_ready), 1);
                if (first_iv < 0 && |in_valid) first_iv = cyc;
                if (first_ov < 0 && out_valid) first_ov = cyc;
                if (stl_prev) begin
                    check("stall_hold_valid", out_valid, 1);
                    check("stall_hold_data", out_data, stl_data);
                    check("stall_hold_eop", out_eop, stl_eop);
                    check("stall_hold_src", out_src, stl_src);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL unexpected_beat: got src %0d data %0h, expected no beat", out_src, out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", out_data, e.data);
                        check("beat_eop", out_eop, e.eop);
                        check("beat_src", out_src, e.src);
                        obs_cyc.push_back(cyc);
                        if (out_eop) obs_src.push_back(int'(out_src));
                    end
                end
                stl_prev = out_valid && !out_ready;
                stl_data = out_data;
                stl_eop  = out_eop;
                stl_src  = out_src;
            end else begin
                stl_prev = 0;
            end
        end
    end

    initial begin
        #950000;
        $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
        $fatal(1, "global timeout");
    end

    initial begin
        int seq[8];
        int t;

        // T1: equal weights, single-beat packets, latency and bubble.
        do_reset();
        set_wt(1, 1, 1, 1);
        out_ready = 1'b1;
        add_pkt(0, 1); add_pkt(1, 1); add_pkt(2, 1); add_pkt(3, 1); add_pkt(0, 1);
        plan();
        enable = 1'b1;
        drain("t1_drain", 100);
        seq = '{0, 1, 2, 3, 0, 0, 0, 0};
        chk_seq("t1_order", seq, 5);
        check("t1_first_latency", first_ov - first_iv, 2);
        for (int k = 1; k < 5; k++) begin
            if (k < obs_cyc.size()) check($sformatf("t1_gap[%0d]", k), obs_cyc[k] - obs_cyc[k-1], 2);
        end

        // T2: weight[1]=3, mixed packet lengths.
        do_reset();
        set_wt(1, 3, 1, 1);
        out_ready = 1'b1;
        add_pkt(0, 2); add_pkt(0, 2);
        for (int k = 0; k < 6; k++) add_pkt(1, 1);
        plan();
        enable = 1'b1;
        drain("t2_drain", 200);
        seq = '{0, 1, 1, 1, 0, 1, 1, 1};
        chk_seq("t2_order", seq, 8);
        if (obs_cyc.size() > 3) check("t2_same_owner_gap", obs_cyc[3] - obs_cyc[2], 2);

        // T2b: zero weight behaves as one.
        do_reset();
        set_wt(0, 1, 1, 0);
        out_ready = 1'b1;
        add_pkt(0, 1); add_pkt(0, 1); add_pkt(3, 2); add_pkt(3, 2);
        plan();
        enable = 1'b1;
        drain("t2b_drain", 100);
        seq = '{0, 3, 0, 3, 0, 0, 0, 0};
        chk_seq("t2b_order", seq, 4);

        // T3: backpressure mid-packet, competing requester arrives later.
        do_reset();
        set_wt(1, 1, 1, 1);
        out_ready = 1'b1;
        add_pkt(2, 4);
        plan();
        enable = 1'b1;
        t = 0;
        while (!in_ready[2] && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) fail_tmo("t3_grant2");
        add_pkt(0, 2);
        plan();
        wait_obs("t3_beats", 2, 30);
        @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
        drain("t3_drain", 100);
        seq = '{2, 0, 0, 0, 0, 0, 0, 0};
        chk_seq("t3_order", seq, 2);

        // T4: enable dropped mid-packet.
        do_reset();
        set_wt(1, 1, 1, 1);
        out_ready = 1'b1;
        add_pkt(0, 5); add_pkt(1, 1); add_pkt(2, 1); add_pkt(0, 1);
        plan();
        enable = 1'b1;
        wait_obs("t4_beat2", 2, 30);
        enable = 1'b0;
        t = 0;
        while (obs_src.size() < 1 && t < 30) begin
            @(negedge clk);
            t++;
        end
        if (t >= 30) fail_tmo("t4_eop");
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t4_idle_in_ready", in_ready, 0);
            check("t4_idle_out_valid", out_valid, 0);
        end
        check("t4_pending_beats", exp_q.size(), 3);
        enable = 1'b1;
        drain("t4_drain", 100);
        seq = '{0, 1, 2, 0, 0, 0, 0, 0};
        chk_seq("t4_order", seq, 4);

        // T5: reset mid-packet.
        do_reset();
        set_wt(1, 1, 1, 1);
        out_ready = 1'b1;
        add_pkt(1, 4);
        plan();
        enable = 1'b1;
        wait_obs("t5_beat1", 1, 30);
        rst_n = 1'b0;
        #1;
        check("t5_rst_out_valid", out_valid, 0);
        check("t5_rst_in_ready", in_ready, 0);
        clear_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        add_pkt(1, 1); add_pkt(0, 1);
        plan();
        drain("t5_drain", 100);
        seq = '{0, 1, 0, 0, 0, 0, 0, 0};
        chk_seq("t5_order", seq, 2);

        // T6: owner stalls mid-packet.
        do_reset();
        set_wt(1, 1, 1, 1);
        out_ready = 1'b1;
        add_pkt(3, 3);
        plan();
        enable = 1'b1;
        wait_obs("t6_beat1", 1, 30);
        hold[3] = 1;
`ifdef NX_WRR_PKT_ARB_WDOG_EN
        repeat (65000) @(negedge clk);
        check("t6_wdog_early", stall_err, 0);
        repeat (600) @(negedge clk);
        check("t6_wdog_set", stall_err, 1);
        hold[3] = 0;
        drain("t6_drain", 100);
        check("t6_wdog_sticky", stall_err, 1);
`else
        repeat (300) @(negedge clk);
        check("t6_stall_err_off", stall_err, 0);
        hold[3] = 0;
        drain("t6_drain", 100);
        check("t6_stall_err_off_end", stall_err, 0);
`endif
        seq = '{3, 0, 0, 0, 0, 0, 0, 0};
        chk_seq("t6_order", seq, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
